sha256_msg_sequencer: RTL and testbench
=======================================

SHA256_MSG_SEQUENCER -- requirements
Module: sha256_msg_sequencer

Interface
REQ-001 Parameter: WAIT_TIMEOUT, 1023, max cycles to wait for core_digest_valid after a core command.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 data_in  in  8  message byte.
REQ-005 data_ready  in  1  data_in valid this cycle.
REQ-006 data_last  in  1  qualified by data_ready; byte is the final message byte.
REQ-007 in_ready  out  1  sequencer accepts a byte this cycle.
REQ-008 core_block  out  512  padded block to SHA-256 core, message byte 0 at [511:504].
REQ-009 core_init  out  1  one-cycle pulse: hash first block with the initial state.
REQ-010 core_next  out  1  one-cycle pulse: hash a subsequent block.
REQ-011 core_ready  in  1  core idle, command accepted.
REQ-012 core_digest_valid  in  1  core finished current block.
REQ-013 msg_done  out  1  one-cycle pulse: final block of the message hashed.
REQ-014 drop_err  out  1  one-cycle pulse: data_ready seen while in_ready=0; byte discarded.
REQ-015 timeout_err  out  1  one-cycle pulse: core wait exceeded WAIT_TIMEOUT.

Function
REQ-016 States: FILL, PAD, LEN, SEND, WAIT; the FSM leaves reset in FILL with first_blk=1, byte index 0, bit count 0.
REQ-017 in_ready SHALL be 1 only in FILL.
REQ-018 FILL: each accepted byte is written at index idx, with idx+1 and bitcnt+8 (64-bit, wraps modulo 2^64).
REQ-019 FILL, idx reaches 64 with data_last=0 -> SEND, final=0, idx cleared after the command.
REQ-020 FILL, data_last=1 -> PAD; if that byte filled idx 63, PAD starts in a fresh block after SEND/WAIT of the full block.
REQ-021 PAD: first write 0x80 (once per message), then 0x00, one byte per cycle until idx=56 -> LEN.
REQ-022 PAD, idx reaches 64 before 56 (0x80 lands at idx>=56) -> SEND with final=0, then resume PAD zeros in the next block from idx 0.
REQ-023 LEN: write bitcnt big-endian at idx 56..63, one byte per cycle -> SEND, final=1.
REQ-024 SEND: in the first cycle with core_ready=1, pulse core_init if first_blk else core_next, clear first_blk -> WAIT; core_block SHALL be stable from SEND entry until WAIT exit.
REQ-025 WAIT: on core_digest_valid -> if final, pulse msg_done, reset bitcnt/first_blk/0x80 flag -> FILL; else -> FILL (or PAD if padding pending), idx=0.
REQ-026 WAIT counter: reaching WAIT_TIMEOUT without core_digest_valid -> pulse timeout_err, abandon message, state as after reset.
REQ-027 Minimum message length is 1 byte; the sequencer ignores data_last without data_ready.
REQ-028 All pulses SHALL be exactly one cycle wide; core_init and core_next never high together.

Reset
REQ-029 rst SHALL force FILL, idx=0, bitcnt=0, first_blk=1, core_block=0, and all pulse outputs 0; rst mid-message discards all buffered data.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 Shared package sha256_pkg holds state encoding, BLOCK_BYTES=64, LEN_OFFSET=56, PAD_BYTE=8'h80.
REQ-032 Single module; the 512-bit buffer and byte writer stay inline, with no sub-module.

Verification
REQ-033 "abc" (61 62 63, last on 63) -> one core_init, core_block=61626380 00.. 00000018, msg_done after digest_valid.
REQ-034 55 bytes -> one block, 0x80 at idx 55, length 0x1B8; 56 bytes -> two blocks, second all-zero but length 0x1C0, core_init then core_next.
REQ-035 64 bytes -> block 1 data only; block 2 = 0x80, zeros, length 0x200; msg_done once.
REQ-036 data_ready pulsed during WAIT -> drop_err 1 cycle, byte absent from core_block.
REQ-037 Core model never asserts digest_valid -> timeout_err at WAIT_TIMEOUT cycles, in_ready=1 next cycle.
REQ-038 rst asserted in WAIT mid-message -> next message "abc" issues core_init, not core_next, with length 0x18.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message sequencer: FSM encoding,
// block geometry constants and the length-field byte selector.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_LEN,
    ST_SEND,
    ST_WAIT
  } state_e;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_OFFSET  = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  // Picks one byte of the 64-bit message length, big-endian: sel=0 is the MSB.
  function automatic logic [7:0] lenByte(input logic [63:0] bitCnt, input logic [2:0] sel);
    logic [63:0] shifted;
    shifted = bitCnt >> {~sel, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/sha256_msg_sequencer.sv
// Turns a byte stream into padded 512-bit SHA-256 blocks and drives the
// core's init/next handshake, including padding, the length field and a
// watchdog on the core's completion signal.
module sha256_msg_sequencer
  import sha256_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   data_in,
  input  logic         data_ready,
  input  logic         data_last,
  output logic         in_ready,
  output logic [511:0] core_block,
  output logic         core_init,
  output logic         core_next,
  input  logic         core_ready,
  input  logic         core_digest_valid,
  output logic         msg_done,
  output logic         drop_err,
  output logic         timeout_err
);

  localparam int              CW          = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [5:0]      LAST_IDX    = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0]      PRE_LEN_IDX = 6'(LEN_OFFSET - 1);
  localparam logic [CW-1:0]   WAIT_LAST   = CW'(WAIT_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [5:0]           idx_q, idx_d;
  logic [63:0]          bitCnt_q, bitCnt_d;
  logic                 firstBlk_q, firstBlk_d;
  logic                 padStarted_q, padStarted_d;
  logic                 final_q, final_d;
  logic                 padPending_q, padPending_d;
  logic [63:0][7:0]     blockBuf_q, blockBuf_d;
  logic [CW-1:0]        waitCnt_q, waitCnt_d;

  // Byte k of the message lives in element ~k so that byte 0 lands in the top bits.
  assign core_block = blockBuf_q;

  // State register: reset abandons any partially buffered message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      idx_q        <= '0;
      bitCnt_q     <= '0;
      firstBlk_q   <= 1'b1;
      padStarted_q <= 1'b0;
      final_q      <= 1'b0;
      padPending_q <= 1'b0;
      blockBuf_q   <= '0;
      waitCnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bitCnt_q     <= bitCnt_d;
      firstBlk_q   <= firstBlk_d;
      padStarted_q <= padStarted_d;
      final_q      <= final_d;
      padPending_q <= padPending_d;
      blockBuf_q   <= blockBuf_d;
      waitCnt_q    <= waitCnt_d;
    end
  end

  // Next-state logic, byte writer and one-cycle status pulses.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bitCnt_d     = bitCnt_q;
    firstBlk_d   = firstBlk_q;
    padStarted_d = padStarted_q;
    final_d      = final_q;
    padPending_d = padPending_q;
    blockBuf_d   = blockBuf_q;
    waitCnt_d    = waitCnt_q;
    in_ready     = (state_q == ST_FILL);
    drop_err     = data_ready && (state_q != ST_FILL);
    core_init    = 1'b0;
    core_next    = 1'b0;
    msg_done     = 1'b0;
    timeout_err  = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (data_ready) begin
          blockBuf_d[~idx_q] = data_in;
          idx_d              = idx_q + 6'd1;
          bitCnt_d           = bitCnt_q + 64'd8;
          if (idx_q == LAST_IDX) begin
            state_d      = ST_SEND;
            final_d      = 1'b0;
            padPending_d = data_last;
          end else if (data_last) begin
            state_d = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        blockBuf_d[~idx_q] = padStarted_q ? 8'h00 : PAD_BYTE;
        padStarted_d       = 1'b1;
        idx_d              = idx_q + 6'd1;
        if (idx_q == PRE_LEN_IDX) begin
          state_d = ST_LEN;
        end else if (idx_q == LAST_IDX) begin
          state_d      = ST_SEND;
          final_d      = 1'b0;
          padPending_d = 1'b1;
        end
      end

      ST_LEN: begin
        blockBuf_d[~idx_q] = lenByte(bitCnt_q, idx_q[2:0]);
        idx_d              = idx_q + 6'd1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_SEND;
          final_d = 1'b1;
        end
      end

      ST_SEND: begin
        if (core_ready) begin
          core_init  = firstBlk_q;
          core_next  = !firstBlk_q;
          firstBlk_d = 1'b0;
          waitCnt_d  = '0;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (core_digest_valid) begin
          idx_d = '0;
          if (final_q) begin
            msg_done     = 1'b1;
            bitCnt_d     = '0;
            firstBlk_d   = 1'b1;
            padStarted_d = 1'b0;
            final_d      = 1'b0;
            state_d      = ST_FILL;
          end else if (padPending_q) begin
            padPending_d = 1'b0;
            state_d      = ST_PAD;
          end else begin
            state_d = ST_FILL;
          end
        end else if (waitCnt_q == WAIT_LAST) begin
          timeout_err  = 1'b1;
          state_d      = ST_FILL;
          idx_d        = '0;
          bitCnt_d     = '0;
          firstBlk_d   = 1'b1;
          padStarted_d = 1'b0;
          final_d      = 1'b0;
          padPending_d = 1'b0;
          blockBuf_d   = '0;
          waitCnt_d    = '0;
        end else begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end

      default: state_d = ST_FILL;
    endcase

    if (rst) begin
      drop_err    = 1'b0;
      core_init   = 1'b0;
      core_next   = 1'b0;
      msg_done    = 1'b0;
      timeout_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Self-checking bench for sha256_msg_sequencer: a reference padding model
// fills a scoreboard of expected blocks, and a behavioural core pops and
// compares them as commands arrive.
module tb_sha256_msg_sequencer;

  localparam int WAIT_TIMEOUT = 1023;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   data_in;
  logic         data_ready;
  logic         data_last;
  logic         in_ready;
  logic [511:0] core_block;
  logic         core_init;
  logic         core_next;
  logic         core_ready = 1'b1;
  logic         core_digest_valid = 1'b0;
  logic         msg_done;
  logic         drop_err;
  logic         timeout_err;

  sha256_msg_sequencer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in          (data_in),
    .data_ready       (data_ready),
    .data_last        (data_last),
    .in_ready         (in_ready),
    .core_block       (core_block),
    .core_init        (core_init),
    .core_next        (core_next),
    .core_ready       (core_ready),
    .core_digest_valid(core_digest_valid),
    .msg_done         (msg_done),
    .drop_err         (drop_err),
    .timeout_err      (timeout_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] blk;
    bit           init;
  } expCmd_t;

  typedef struct {
    int len;
    int expBlocks;
  } vec_t;

  expCmd_t      sbQ[$];
  vec_t         vecs[8];
  logic [7:0]   msgBuf[256];

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int cmdCount = 0;
  int doneCount = 0;
  int dropCount = 0;
  int timeoutCount = 0;
  int cmdCycle = 0;
  int timeoutDelta = 0;
  int coreLatMax = 4;
  bit noDigest = 1'b0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural core plus monitor: samples DUT outputs mid-cycle, then
  // drives the core handshake just after the next rising edge.
  always begin : coreModel
    bit      coreBusy;
    bit      nextReady;
    bit      nextValid;
    bit      checkReadyNext;
    int      latLeft;
    logic [511:0] heldBlk;
    expCmd_t e;
    coreBusy = 1'b0;
    checkReadyNext = 1'b0;
    latLeft = 0;
    heldBlk = '0;
    forever begin
      @(negedge clk);
      cycleCnt++;
      nextReady = core_ready;
      nextValid = core_digest_valid;
      if (rst) begin
        coreBusy = 1'b0;
        nextReady = 1'b1;
        nextValid = 1'b0;
        checkReadyNext = 1'b0;
      end else begin
        if (checkReadyNext) begin
          checkOutput("in_ready_after_timeout", in_ready, 1);
          checkReadyNext = 1'b0;
        end
        if (core_init || core_next) begin
          checkOutput("init_next_exclusive", core_init & core_next, 0);
          cmdCount++;
          cmdCycle = cycleCnt;
          heldBlk = core_block;
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_cmd actual=command required=none");
          end else begin
            e = sbQ.pop_front();
            checkOutput("cmd_block", core_block, e.blk);
            checkOutput("cmd_is_init", core_init, e.init);
          end
          coreBusy = 1'b1;
          latLeft = $urandom_range(1, coreLatMax);
          nextReady = 1'b0;
        end else if (core_digest_valid) begin
          checkOutput("block_stable", core_block, heldBlk);
          coreBusy = 1'b0;
          nextValid = 1'b0;
          nextReady = 1'b1;
        end else if (coreBusy) begin
          if (!noDigest) begin
            latLeft--;
            if (latLeft <= 0) nextValid = 1'b1;
          end
        end else begin
          nextReady = ($urandom_range(0, 3) != 0);
        end
        if (msg_done) doneCount++;
        if (drop_err) dropCount++;
        if (timeout_err) begin
          timeoutCount++;
          timeoutDelta = cycleCnt - cmdCycle;
          coreBusy = 1'b0;
          nextReady = 1'b1;
          checkReadyNext = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      core_ready = nextReady;
      core_digest_valid = nextValid;
    end
  end

  // Reference SHA-256 padding of msgBuf[0..len-1], queued block by block.
  task automatic pushModel(input int len);
    int nb;
    int total;
    int i;
    logic [63:0] bitLen;
    logic [7:0]  pb;
    expCmd_t     e;
    nb = (len + 8) / 64 + 1;
    total = nb * 64;
    bitLen = 64'(len) * 64'd8;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int j = 0; j < 64; j++) begin
        i = b * 64 + j;
        if (i < len) pb = msgBuf[i];
        else if (i == len) pb = 8'h80;
        else if (i >= total - 8) pb = bitLen[8 * (total - 1 - i) +: 8];
        else pb = 8'h00;
        e.blk[511 - 8 * j -: 8] = pb;
      end
      e.init = (b == 0);
      sbQ.push_back(e);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit last);
    int guard;
    guard = 0;
    while (!in_ready && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_wait actual=0 required=1");
    end
    data_in = b;
    data_ready = 1'b1;
    data_last = last;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    data_last = 1'b0;
  endtask

  // Streams msgBuf with random idle gaps; idle cycles toggle data_last alone.
  task automatic applyStimulus(input int len, input bit withLast);
    for (int k = 0; k < len; k++) begin
      repeat ($urandom_range(0, 1)) begin
        data_last = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        data_last = 1'b0;
      end
      sendByte(msgBuf[k], withLast && (k == len - 1));
    end
  endtask

  task automatic waitCmd(input int startCnt, input string name);
    int g;
    g = 0;
    while (cmdCount == startCnt && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput(name, cmdCount - startCnt, 1);
  endtask

  task automatic waitDone(input int startDone, input string name);
    int g;
    g = 0;
    while (doneCount == startDone && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput(name, doneCount - startDone, 1);
  endtask

  task automatic loadAbc();
    msgBuf[0] = 8'h61;
    msgBuf[1] = 8'h62;
    msgBuf[2] = 8'h63;
  endtask

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int startCmd;
    int startDone;
    int startDrop;
    int startTo;
    int g;
    expCmd_t e;

    vecs[0] = '{1, 1};
    vecs[1] = '{55, 1};
    vecs[2] = '{56, 2};
    vecs[3] = '{63, 2};
    vecs[4] = '{64, 2};
    vecs[5] = '{65, 2};
    vecs[6] = '{119, 2};
    vecs[7] = '{120, 3};

    rst = 1'b1;
    data_in = 8'h00;
    data_ready = 1'b0;
    data_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pulses", {core_init, core_next, msg_done, drop_err, timeout_err}, 0);
    rst = 1'b0;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_block", core_block, 0);

    // "abc": single block, literal expected image.
    loadAbc();
    e.blk = ABC_BLK;
    e.init = 1'b1;
    sbQ.push_back(e);
    startCmd = cmdCount;
    startDone = doneCount;
    applyStimulus(3, 1'b1);
    waitDone(startDone, "abc_done");
    checkOutput("abc_cmds", cmdCount - startCmd, 1);

    // Table of lengths around the padding and block boundaries.
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < vecs[v].len; k++) msgBuf[k] = 8'($urandom);
      pushModel(vecs[v].len);
      startCmd = cmdCount;
      startDone = doneCount;
      applyStimulus(vecs[v].len, 1'b1);
      waitDone(startDone, $sformatf("len%0d_done", vecs[v].len));
      checkOutput($sformatf("len%0d_blocks", vecs[v].len), cmdCount - startCmd, vecs[v].expBlocks);
      checkOutput($sformatf("len%0d_sb_empty", vecs[v].len), sbQ.size(), 0);
    end

    // A byte offered while the core is busy is dropped and flagged once.
    coreLatMax = 6;
    loadAbc();
    e.blk = ABC_BLK;
    e.init = 1'b1;
    sbQ.push_back(e);
    startCmd = cmdCount;
    startDone = doneCount;
    startDrop = dropCount;
    applyStimulus(3, 1'b1);
    waitCmd(startCmd, "drop_cmd_seen");
    data_in = 8'hFF;
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    waitDone(startDone, "drop_done");
    checkOutput("drop_count", dropCount - startDrop, 1);

    // Core never completes: watchdog fires after WAIT_TIMEOUT cycles.
    noDigest = 1'b1;
    loadAbc();
    e.blk = ABC_BLK;
    e.init = 1'b1;
    sbQ.push_back(e);
    startDone = doneCount;
    startTo = timeoutCount;
    applyStimulus(3, 1'b1);
    g = 0;
    while (timeoutCount == startTo && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("timeout_seen", timeoutCount - startTo, 1);
    checkOutput("timeout_latency", timeoutDelta, WAIT_TIMEOUT);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("timeout_no_done", doneCount - startDone, 0);
    checkOutput("timeout_block_cleared", core_block, 0);
    noDigest = 1'b0;

    // Reset while waiting on the core, mid-message; the next message restarts with init.
    coreLatMax = 40;
    for (int k = 0; k < 64; k++) msgBuf[k] = 8'($urandom);
    e.blk = '0;
    for (int j = 0; j < 64; j++) e.blk[511 - 8 * j -: 8] = msgBuf[j];
    e.init = 1'b1;
    sbQ.push_back(e);
    startCmd = cmdCount;
    applyStimulus(64, 1'b0);
    waitCmd(startCmd, "midrst_cmd_seen");
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_block", core_block, 0);
    coreLatMax = 4;
    loadAbc();
    e.blk = ABC_BLK;
    e.init = 1'b1;
    sbQ.push_back(e);
    startCmd = cmdCount;
    startDone = doneCount;
    applyStimulus(3, 1'b1);
    waitDone(startDone, "midrst_abc_done");
    checkOutput("midrst_abc_cmds", cmdCount - startCmd, 1);
    checkOutput("final_sb_empty", sbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
